ex_mem_latch: RTL and testbench
===============================

EX_MEM_LATCH -- requirements
Module: ex_mem_latch

Interface
REQ-001 The module SHALL have ports, in this order (name, direction, width, meaning):
  CLK  in  1  the single clock; all state changes on its rising edge.
  nRST  in  1  reset, asynchronous, active-low.
  ihit  in  1  instruction fetch completed; pipeline advance permitted.
  dhit  in  1  data memory completed the current request.
  flush  in  1  squash; insert a bubble at the next advance.
  regwrite_ex  in  1  EX instruction writes the register file.
  memtoreg_ex  in  2  writeback select (0 ALU, 1 memory, 2 PC+4).
  memread_ex  in  1  EX instruction is a load.
  memwrite_ex  in  1  EX instruction is a store.
  halt_ex  in  1  EX instruction is HALT.
  branchdest_ex  in  5  destination register number.
  aluout_ex  in  32  ALU result or effective address.
  storedata_ex  in  32  forwarded rt value to store.
  pcplus4_ex  in  32  PC+4 of the EX instruction.
  dmemload  in  32  data returned by memory.
  regwrite_ex_mem_output, memtoreg_ex_mem_output[2], branchdest_ex_mem_output[5], aluout_ex_mem_output[32], pcplus4_ex_mem_output[32], halt_ex_mem_output  out  latched copies.
  loaddata_ex_mem_output  out  32  dmemload captured on dhit.
  dmemREN, dmemWEN  out  1  data memory read/write request.
  dmemaddr, dmemstore  out  32  request address and store data.
  mem_stall  out  1  memory access outstanding; upstream stages hold.

Function
REQ-002 The FSM SHALL have states IDLE, REQ, DONE.
REQ-003 advance SHALL equal ihit AND state != REQ.
REQ-004 On advance with flush=0, every *_ex input SHALL be captured; with flush=1, all control bits (regwrite, memtoreg, memread, memwrite) SHALL load 0, branchdest SHALL load 0 and data fields are don't-care.
REQ-005 Without advance, all latched fields SHALL hold their value.
REQ-006 On advance capturing memread or memwrite = 1 (not flushed), next state SHALL be REQ; otherwise next state SHALL be IDLE.
REQ-007 In REQ, dmemREN SHALL equal latched memread and dmemWEN latched memwrite; both SHALL be 0 in IDLE and DONE.
REQ-008 dmemaddr SHALL equal latched aluout and dmemstore latched storedata in every state.
REQ-009 In REQ with dhit=1, loaddata SHALL capture dmemload and the state SHALL become DONE; without dhit, the state SHALL remain REQ.
REQ-010 In DONE, the state SHALL hold until advance, then follow REQ-006.
REQ-011 mem_stall SHALL equal (state == REQ), combinationally.
REQ-012 flush while in REQ SHALL NOT abort the outstanding access; the flush applies only at the next advance.
REQ-013 halt_ex_mem_output SHALL be sticky: once set by a non-flushed capture, it stays 1 until reset.
REQ-014 ihit and dhit in the same REQ cycle SHALL complete the access (DONE) without advancing; advance occurs no earlier than the following cycle.
REQ-015 Latency SHALL be exactly one clock from an advance to the captured fields on the outputs.

Reset
REQ-016 When nRST=0, all outputs and latched fields SHALL be 0 and state SHALL be IDLE, immediately and independently of CLK.
REQ-017 A reset asserted while in REQ SHALL drop dmemREN/dmemWEN in the same cycle and discard the access.

Structure
REQ-018 word_t (32-bit), regbits_t (5-bit) and the FSM state enum SHALL be defined in cpu_types_pkg.
REQ-019 The block SHALL be one module with no sub-modules; the forwarding unit consumes its regwrite, memtoreg and branchdest outputs directly.

Verification
REQ-020 ALU op: ihit=1, regwrite_ex=1, branchdest_ex=5, aluout_ex=0x10 -> next cycle regwrite=1, branchdest=5, aluout=0x10, mem_stall=0.
REQ-021 Load: capture memread_ex=1, aluout_ex=0x100 -> REQ, dmemREN=1, dmemaddr=0x100, mem_stall=1; dhit after 3 cycles with dmemload=0xDEADBEEF -> DONE, loaddata=0xDEADBEEF, dmemREN=0.
REQ-022 Store stall: memwrite_ex=1, storedata_ex=0xCAFE, ihit held 1 and dhit=0 for 4 cycles -> all fields held, dmemWEN=1, dmemstore=0xCAFE throughout.
REQ-023 Flush: flush=1 with ihit=1, regwrite_ex=1, branchdest_ex=7 -> regwrite=0, branchdest=0, state IDLE.
REQ-024 Reset in REQ: nRST pulled low mid-access -> dmemREN=0, state IDLE, all outputs 0 before the next CLK edge.
REQ-025 Halt: capture halt_ex=1, then an ordinary instruction -> halt_ex_mem_output stays 1.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, register index,
// EX/MEM FSM state and the EX/MEM latched bundle.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic       regwrite;
        logic [1:0] memtoreg;
        logic       memread;
        logic       memwrite;
        logic       halt;
        regbits_t   branchdest;
        word_t      aluout;
        word_t      storedata;
        word_t      pcplus4;
    } ex_mem_t;

endpackage

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline latch with the data-memory request FSM;
// holds the pipeline while a load/store is outstanding.
module ex_mem_latch
    import cpu_types_pkg::*;
(
    input  logic       CLK,
    input  logic       nRST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic       flush,
    input  logic       regwrite_ex,
    input  logic [1:0] memtoreg_ex,
    input  logic       memread_ex,
    input  logic       memwrite_ex,
    input  logic       halt_ex,
    input  regbits_t   branchdest_ex,
    input  word_t      aluout_ex,
    input  word_t      storedata_ex,
    input  word_t      pcplus4_ex,
    input  word_t      dmemload,
    output logic       regwrite_ex_mem_output,
    output logic [1:0] memtoreg_ex_mem_output,
    output regbits_t   branchdest_ex_mem_output,
    output word_t      aluout_ex_mem_output,
    output word_t      pcplus4_ex_mem_output,
    output logic       halt_ex_mem_output,
    output word_t      loaddata_ex_mem_output,
    output logic       dmemREN,
    output logic       dmemWEN,
    output word_t      dmemaddr,
    output word_t      dmemstore,
    output logic       mem_stall
);

    state_t  r_state;
    state_t  w_next;
    ex_mem_t r_q;
    word_t   r_load;
    logic    w_adv;
    logic    w_mem_op;

    assign w_adv    = ihit && (r_state != REQ);
    assign w_mem_op = !flush && (memread_ex || memwrite_ex);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, DONE: begin
                if (w_adv)
                    w_next = w_mem_op ? REQ : IDLE;
            end
            REQ: begin
                if (dhit)
                    w_next = DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // a flushed capture leaves a bubble but never clears a seen HALT
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_q <= '0;
        end else if (w_adv) begin
            r_q.aluout    <= aluout_ex;
            r_q.storedata <= storedata_ex;
            r_q.pcplus4   <= pcplus4_ex;
            if (flush) begin
                r_q.regwrite   <= 1'b0;
                r_q.memtoreg   <= 2'd0;
                r_q.memread    <= 1'b0;
                r_q.memwrite   <= 1'b0;
                r_q.branchdest <= '0;
            end else begin
                r_q.regwrite   <= regwrite_ex;
                r_q.memtoreg   <= memtoreg_ex;
                r_q.memread    <= memread_ex;
                r_q.memwrite   <= memwrite_ex;
                r_q.branchdest <= branchdest_ex;
                r_q.halt       <= r_q.halt | halt_ex;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_load <= '0;
        else if (r_state == REQ && dhit)
            r_load <= dmemload;
    end

    assign mem_stall = (r_state == REQ);
    assign dmemREN   = mem_stall && r_q.memread;
    assign dmemWEN   = mem_stall && r_q.memwrite;
    assign dmemaddr  = r_q.aluout;
    assign dmemstore = r_q.storedata;

    assign regwrite_ex_mem_output   = r_q.regwrite;
    assign memtoreg_ex_mem_output   = r_q.memtoreg;
    assign branchdest_ex_mem_output = r_q.branchdest;
    assign aluout_ex_mem_output     = r_q.aluout;
    assign pcplus4_ex_mem_output    = r_q.pcplus4;
    assign halt_ex_mem_output       = r_q.halt;
    assign loaddata_ex_mem_output   = r_load;

endmodule

// File: tb/tb_ex_mem_latch.sv
// Directed and random checks of ex_mem_latch against
// a transaction-level model of the EX/MEM stage.
module tb_ex_mem_latch;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, flush;
    logic        regwrite_ex, memread_ex, memwrite_ex, halt_ex;
    logic [1:0]  memtoreg_ex;
    logic [4:0]  branchdest_ex;
    logic [31:0] aluout_ex, storedata_ex, pcplus4_ex, dmemload;
    logic        o_rw, o_halt, dmemREN, dmemWEN, mem_stall;
    logic [1:0]  o_mt;
    logic [4:0]  o_bd;
    logic [31:0] o_alu, o_pc, o_ld, dmemaddr, dmemstore;

    int errors = 0;
    int checks = 0;

    // model: latched instruction plus "access outstanding" flag
    bit          m_rw, m_mr, m_mw, m_halt, m_busy, m_dvalid;
    bit [1:0]    m_mt;
    bit [4:0]    m_bd;
    bit [31:0]   m_alu, m_sd, m_pc, m_ld;

    always #5 CLK = ~CLK;

    ex_mem_latch dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .flush(flush), .regwrite_ex(regwrite_ex),
        .memtoreg_ex(memtoreg_ex), .memread_ex(memread_ex),
        .memwrite_ex(memwrite_ex), .halt_ex(halt_ex),
        .branchdest_ex(branchdest_ex), .aluout_ex(aluout_ex),
        .storedata_ex(storedata_ex), .pcplus4_ex(pcplus4_ex),
        .dmemload(dmemload),
        .regwrite_ex_mem_output(o_rw),
        .memtoreg_ex_mem_output(o_mt),
        .branchdest_ex_mem_output(o_bd),
        .aluout_ex_mem_output(o_alu),
        .pcplus4_ex_mem_output(o_pc),
        .halt_ex_mem_output(o_halt),
        .loaddata_ex_mem_output(o_ld),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_stall(mem_stall)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".mem_stall"}, 32'(mem_stall), 32'(m_busy));
        chk({tag, ".dmemREN"}, 32'(dmemREN), 32'(m_busy & m_mr));
        chk({tag, ".dmemWEN"}, 32'(dmemWEN), 32'(m_busy & m_mw));
        chk({tag, ".regwrite"}, 32'(o_rw), 32'(m_rw));
        chk({tag, ".memtoreg"}, 32'(o_mt), 32'(m_mt));
        chk({tag, ".branchdest"}, 32'(o_bd), 32'(m_bd));
        chk({tag, ".halt"}, 32'(o_halt), 32'(m_halt));
        chk({tag, ".loaddata"}, o_ld, m_ld);
        if (m_dvalid) begin
            chk({tag, ".aluout"}, o_alu, m_alu);
            chk({tag, ".pcplus4"}, o_pc, m_pc);
            chk({tag, ".dmemaddr"}, dmemaddr, m_alu);
            chk({tag, ".dmemstore"}, dmemstore, m_sd);
        end
    endtask

    task automatic model_reset();
        {m_rw, m_mr, m_mw, m_halt, m_busy} = '0;
        m_mt = 0; m_bd = 0;
        m_alu = 0; m_sd = 0; m_pc = 0; m_ld = 0;
        m_dvalid = 1;
    endtask

    task automatic quiet();
        {ihit, dhit, flush, regwrite_ex, memread_ex} = '0;
        {memwrite_ex, halt_ex} = '0;
        memtoreg_ex = 0; branchdest_ex = 0;
        aluout_ex = 0; storedata_ex = 0; pcplus4_ex = 0;
        dmemload = 0;
    endtask

    // advance the model by one clock, then compare after the edge
    task automatic tick(string tag);
        bit adv;
        adv = ihit && !m_busy;
        if (m_busy && dhit) begin
            m_ld = dmemload;
            m_busy = 0;
        end
        if (adv) begin
            if (flush) begin
                {m_rw, m_mr, m_mw} = '0;
                m_mt = 0; m_bd = 0;
                m_dvalid = 0;
            end else begin
                m_rw = regwrite_ex; m_mt = memtoreg_ex;
                m_mr = memread_ex; m_mw = memwrite_ex;
                m_bd = branchdest_ex; m_alu = aluout_ex;
                m_sd = storedata_ex; m_pc = pcplus4_ex;
                m_halt = m_halt | halt_ex;
                m_dvalid = 1;
                m_busy = memread_ex || memwrite_ex;
            end
        end
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    initial begin
        quiet();
        nRST = 1'b0;
        model_reset();
        #3;
        check_all("reset");
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // ALU op
        ihit = 1; regwrite_ex = 1; branchdest_ex = 5;
        aluout_ex = 32'h10; pcplus4_ex = 32'h44;
        tick("alu");
        chk("alu.rw_const", 32'(o_rw), 32'd1);
        chk("alu.bd_const", 32'(o_bd), 32'd5);
        chk("alu.alu_const", o_alu, 32'h10);

        // load with dhit after 3 waiting cycles
        quiet();
        ihit = 1; memread_ex = 1; regwrite_ex = 1;
        memtoreg_ex = 1; aluout_ex = 32'h100; branchdest_ex = 3;
        tick("load.cap");
        chk("load.ren_const", 32'(dmemREN), 32'd1);
        chk("load.addr_const", dmemaddr, 32'h100);
        quiet();
        dmemload = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) tick("load.wait");
        dhit = 1;
        tick("load.done");
        chk("load.data_const", o_ld, 32'hDEADBEEF);
        chk("load.ren_off", 32'(dmemREN), 32'd0);
        dhit = 0;
        tick("load.done_hold");

        // store held with ihit=1, dhit=0
        ihit = 1; memwrite_ex = 1; storedata_ex = 32'hCAFE;
        aluout_ex = 32'h200;
        tick("store.cap");
        memwrite_ex = 0; storedata_ex = 32'h1234;
        aluout_ex = 32'h999; regwrite_ex = 1; branchdest_ex = 9;
        for (int i = 0; i < 4; i++) begin
            tick("store.stall");
            chk("store.wen_const", 32'(dmemWEN), 32'd1);
            chk("store.sd_const", dmemstore, 32'hCAFE);
        end
        // ihit and dhit together complete but do not advance
        dhit = 1; flush = 1;
        tick("store.done");
        quiet();
        tick("store.idle");

        // flush bubble
        ihit = 1; flush = 1; regwrite_ex = 1; branchdest_ex = 7;
        memread_ex = 1;
        tick("flush");
        chk("flush.rw_const", 32'(o_rw), 32'd0);
        chk("flush.stall_const", 32'(mem_stall), 32'd0);

        // halt is sticky
        quiet();
        ihit = 1; halt_ex = 1;
        tick("halt.set");
        halt_ex = 0; regwrite_ex = 1; branchdest_ex = 2;
        tick("halt.next");
        chk("halt.sticky", 32'(o_halt), 32'd1);

        // reset mid-access
        quiet();
        ihit = 1; memread_ex = 1; aluout_ex = 32'h300;
        tick("rst.cap");
        quiet();
        nRST = 1'b0;
        #1;
        model_reset();
        check_all("rst.async");
        #3;
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        check_all("rst.after");

        // random traffic
        for (int n = 0; n < 400; n++) begin
            ihit = ($urandom_range(3) != 0);
            dhit = ($urandom_range(1) == 0);
            flush = ($urandom_range(6) == 0);
            regwrite_ex = 1'($urandom);
            memtoreg_ex = 2'($urandom_range(2));
            memread_ex = ($urandom_range(3) == 0);
            memwrite_ex = !memread_ex && ($urandom_range(3) == 0);
            halt_ex = ($urandom_range(40) == 0);
            branchdest_ex = 5'($urandom);
            aluout_ex = $urandom;
            storedata_ex = $urandom;
            pcplus4_ex = $urandom;
            dmemload = $urandom;
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
